// File: rtl/song_play_ctrl.sv
// song_play_ctrl: auto-play scheduler. Generates the tempo-scaled beat tick, steps the song-ROM
// address, runs the IDLE/PLAY/PAUSE play control and arbitrates the note between live keys and the ROM.
//   clk_i, rst_i           clock, asynchronous active-high reset
//   play_btn_i, stop_btn_i single-cycle button pulses (start/pause/resume, stop/rewind)
//   loop_en_i, tempo_i     loop at song end; beat period = BASE_DIV*(tempo_i+1) cycles
//   song_sel_i             song choice, latched at start
//   manual_note_i          live key note, NOTE_NONE when no key is held (has priority)
//   rom_note_i             song-ROM data for (song_sel_o, step_addr_o)
//   step_addr_o, song_sel_o, note_out_o, playing_o, beat_tick_o, done_o
module song_play_ctrl #(
  parameter int BASE_DIV = 3_125_000,
  parameter int STEPS = 64,
  parameter logic [3:0] NOTE_NONE = 4'd0,
  parameter int CNT_W = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       play_btn_i,
  input  logic       stop_btn_i,
  input  logic       loop_en_i,
  input  logic [1:0] tempo_i,
  input  logic       song_sel_i,
  input  logic [3:0] manual_note_i,
  input  logic [3:0] rom_note_i,
  output logic [5:0] step_addr_o,
  output logic       song_sel_o,
  output logic [3:0] note_out_o,
  output logic       playing_o,
  output logic       beat_tick_o,
  output logic       done_o
);
  localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, period_new;
  logic song_q, song_d, tick_q, tick_d, done_q, done_d, manual, at_end;
  logic [3:0] note_q, note_d;
  assign manual = manual_note_i != NOTE_NONE;
  assign period_new = CNT_W'(BASE_DIV) * CNT_W'(tempo_i) + CNT_W'(BASE_DIV);
  assign at_end = cnt_q == period_q - CNT_W'(1);
  assign step_addr_o = 6'(step_q);
  assign song_sel_o = song_q;
  assign note_out_o = note_q;
  assign playing_o = state_q == PLAY;
  assign beat_tick_o = tick_q;
  assign done_o = done_q;
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    cnt_d = cnt_q;
    period_d = period_q;
    song_d = song_q;
    tick_d = 1'b0;
    done_d = 1'b0;
    note_d = manual ? manual_note_i : (state_q == PLAY ? rom_note_i : NOTE_NONE);
    if (stop_btn_i) begin
      state_d = IDLE;
      step_d = '0;
      cnt_d = '0;
    end else if (play_btn_i) begin
      state_d = state_q == PLAY ? PAUSE : PLAY;
      if (state_q == IDLE) begin
        song_d = song_sel_i;
        period_d = period_new;
        step_d = '0;
        cnt_d = '0;
      end
    end else if (state_q == PLAY && !manual) begin
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
      if (at_end) begin
        tick_d = 1'b1;
        // tempo is only re-sampled here so every beat has a whole period
        period_d = period_new;
        step_d = step_q + SW'(1);
        if (step_q == SW'(STEPS - 1)) begin
          step_d = '0;
          if (!loop_en_i) begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      step_q <= '0;
      cnt_q <= '0;
      period_q <= CNT_W'(BASE_DIV);
      song_q <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
      note_q <= NOTE_NONE;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      song_q <= song_d;
      tick_q <= tick_d;
      done_q <= done_d;
      note_q <= note_d;
    end
  end
endmodule

// File: tb/tb_song_play_ctrl.sv
// tb_song_play_ctrl: directed scoreboard bench for song_play_ctrl (BASE_DIV=4, STEPS=8).
module tb_song_play_ctrl;
  logic clk = 0, rst = 1, play = 0, stop = 0, loop_en = 0, song_in = 0;
  logic [1:0] tempo = 0;
  logic [3:0] manual = 0, rom, note;
  logic [5:0] step;
  logic song, playing, tick_o, done;
  int checks = 0, errors = 0, cyc = 0, c = 0;
  typedef struct {int cyc; logic [5:0] step; logic done; logic playing;} exp_t;
  exp_t q[$];
  exp_t e;
  song_play_ctrl #(.BASE_DIV(4), .STEPS(8), .NOTE_NONE(4'd0), .CNT_W(24)) dut (
    .clk_i(clk), .rst_i(rst), .play_btn_i(play), .stop_btn_i(stop), .loop_en_i(loop_en),
    .tempo_i(tempo), .song_sel_i(song_in), .manual_note_i(manual), .rom_note_i(rom),
    .step_addr_o(step), .song_sel_o(song), .note_out_o(note), .playing_o(playing),
    .beat_tick_o(tick_o), .done_o(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // song 0 plays notes 1..8, song 1 plays 8..15
  assign rom = song ? 4'd8 + {1'b0, step[2:0]} : 4'd1 + {1'b0, step[2:0]};
  always @(negedge clk) begin
    if (!rst && (tick_o || done)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL tick: unexpected tick=%0d done=%0d step=%0d at cycle %0d", tick_o, done, step, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.step != step || e.done != done || e.playing != playing || !tick_o) begin
          errors++;
          $display("FAIL tick: got cyc=%0d step=%0d done=%0d playing=%0d tick=%0d, want cyc=%0d step=%0d done=%0d playing=%0d",
                   cyc, step, done, playing, tick_o, e.cyc, e.step, e.done, e.playing);
        end
      end
    end
  end
  task automatic tk(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic start(bit s, bit [1:0] t, bit lp);
    song_in = s;
    tempo = t;
    loop_en = lp;
    play = 1;
    tk();
    play = 0;
    c = cyc;
  endtask
  task automatic push(int dc, int st, bit d, bit p);
    q.push_back(exp_t'{c + dc, 6'(st), d, p});
  endtask
  task automatic halt();
    stop = 1;
    tk();
    stop = 0;
  endtask
  initial begin
    tk(2);
    rst = 0;
    tk();
    chk("rst_step", step, 0);
    chk("rst_note", note, 0);
    chk("rst_playing", playing, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_done", done, 0);
    chk("rst_song", song, 0);
    // full song, no loop
    start(0, 0, 0);
    for (int k = 1; k <= 8; k++) push(4 * k, k % 8, k == 8, k < 8);
    tk();
    chk("first_note", note, 1);
    tk(31);
    chk("last_note", note, 8);
    chk("end_step", step, 0);
    chk("end_playing", playing, 0);
    tk();
    chk("end_note_none", note, 0);
    // tempo change lands on the beat boundary
    start(0, 2, 0);
    push(12, 1, 0, 1);
    push(16, 2, 0, 1);
    push(20, 3, 0, 1);
    tk(5);
    tempo = 0;
    tk(16);
    halt();
    chk("tempo_stop_step", step, 0);
    chk("tempo_stop_playing", playing, 0);
    // pause at step 3 / count 2, resume
    start(0, 0, 0);
    for (int k = 1; k <= 3; k++) push(4 * k, k, 0, 1);
    tk(14);
    play = 1;
    tk();
    play = 0;
    chk("pause_note_last", note, 4);
    tk();
    chk("pause_note_none", note, 0);
    chk("pause_playing", playing, 0);
    tk(19);
    chk("pause_step_held", step, 3);
    push(38, 4, 0, 1);
    play = 1;
    tk();
    play = 0;
    chk("resume_playing", playing, 1);
    tk(2);
    halt();
    // loop through the wrap, then stop+play together
    start(0, 0, 1);
    for (int k = 1; k <= 9; k++) push(4 * k, k % 8, 0, 1);
    tk(33);
    chk("loop_playing", playing, 1);
    chk("loop_step", step, 0);
    tk(3);
    stop = 1;
    play = 1;
    tk();
    stop = 0;
    play = 0;
    chk("stop_wins_playing", playing, 0);
    chk("stop_wins_step", step, 0);
    // manual override freezes counting for 10 cycles
    start(0, 0, 0);
    push(4, 1, 0, 1);
    push(18, 2, 0, 1);
    tk(5);
    manual = 5;
    tk();
    chk("manual_note", note, 5);
    tk(9);
    chk("manual_note_held", note, 5);
    chk("manual_step_frozen", step, 1);
    chk("manual_playing", playing, 1);
    manual = 0;
    tk();
    chk("release_note_rom", note, 2);
    tk(2);
    chk("release_step", step, 2);
    halt();
    manual = 5;
    tk();
    chk("idle_manual_note", note, 5);
    manual = 0;
    tk();
    chk("idle_note_none", note, 0);
    // async reset mid-beat
    start(1, 0, 0);
    push(4, 1, 0, 1);
    tk();
    chk("song_latched", song, 1);
    chk("song1_note", note, 8);
    tk(5);
    rst = 1;
    #1;
    chk("arst_step", step, 0);
    chk("arst_playing", playing, 0);
    chk("arst_note", note, 0);
    chk("arst_song", song, 0);
    chk("arst_tick", tick_o, 0);
    chk("arst_done", done, 0);
    tk();
    rst = 0;
    start(0, 0, 0);
    push(4, 1, 0, 1);
    tk();
    chk("restart_step", step, 0);
    tk(3);
    chk("restart_tick_step", step, 1);
    tk();
    halt();
    tk(2);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/song_play_ctrl.md
Name: song_play_ctrl

Overview:
- Playback scheduler for the auto-play piano path.
- Generates the quarter-beat tick at a selectable tempo and steps a song-ROM address counter.
- Handles play/pause/stop/loop and arbitrates the single note output between the live keyboard (manual, priority) and the song ROM (auto).
- Sits between the button/key debouncers and the tone generator. The song ROM is a combinational lookup (step address + song select -> 4-bit note) outside this block.

Parameters:
- BASE_DIV, 3_125_000, clock cycles per quarter beat at fastest tempo (tempo=0).
- STEPS, 64, song length in quarter beats; must be a power of 2, max 64.
- NOTE_NONE, 4'd0, note code meaning silence.
- CNT_W, 24, beat counter width; must hold 4*BASE_DIV-1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- play_btn  in  1  single-cycle pulse, debounced upstream; start / pause / resume.
- stop_btn  in  1  single-cycle pulse; stop and rewind.
- loop_en  in  1  1 = restart at step 0 after the last step.
- tempo  in  2  beat period = BASE_DIV*(tempo+1) cycles.
- song_sel_in  in  1  song choice, latched at start.
- manual_note  in  4  live key note; NOTE_NONE when no key is held.
- rom_note  in  4  song-ROM data for (song_sel, step_addr), valid the same cycle.
- step_addr  out  6  current song step (upper bits 0 if STEPS<64).
- song_sel  out  1  latched song select.
- note_out  out  4  registered note to the tone generator.
- playing  out  1  1 in PLAY state.
- beat_tick  out  1  one-cycle pulse at each step advance.
- done  out  1  one-cycle pulse when a non-looping song ends.

Behaviour:
- FSM states: IDLE, PLAY, PAUSE.
- Reset values: state IDLE, step_addr 0, beat_cnt 0, period BASE_DIV, song_sel 0, note_out NONE, playing/beat_tick/done 0.
- IDLE + play_btn -> PLAY:
  - latch song_sel <= song_sel_in and period <= BASE_DIV*(tempo+1);
  - step_addr 0, beat_cnt 0.
- PLAY + play_btn -> PAUSE, with beat_cnt and step_addr held.
- PAUSE + play_btn -> PLAY, resuming from the held count.
- stop_btn in any state -> IDLE, step_addr 0, beat_cnt 0, no done pulse.
- stop_btn and play_btn in the same cycle: stop wins.
- Manual override: manual_active = (manual_note != NOTE_NONE).
  - While manual_active in PLAY: beat_cnt and step_addr freeze and no tick is generated.
  - Counting continues from the held value on release. The state stays PLAY and playing stays 1.
- Beat counter, only in PLAY with !manual_active: beat_cnt increments each cycle.
  - When beat_cnt == period-1: beat_cnt <= 0 and beat_tick = 1 for one cycle (registered, same edge as the step update).
  - step_addr advances on that edge, and period re-latches from the current tempo, so tempo changes take effect at beat boundaries only.
- Last step (step_addr == STEPS-1) on a tick:
  - loop_en=1: step_addr <= 0, stay PLAY.
  - loop_en=0: -> IDLE, step_addr 0, done = 1 for one cycle, concurrent with beat_tick.
- Arbitration, note_out registered with one cycle latency:
  - manual_active: note_out <= manual_note, in every state.
  - else PLAY: note_out <= rom_note.
  - else IDLE/PAUSE: note_out <= NOTE_NONE.
- The first auto note appears on note_out 1 cycle after play_btn is accepted (rom_note at step 0).
- step_addr width rule: counter is log2(STEPS) bits, zero-extended to 6 bits; wrap is explicit at STEPS-1, never by overflow.
- Reset mid-play: all registers return to reset values immediately (async); the next play_btn starts from step 0.
- play_btn while in PLAY during manual override still pauses.

Test Plan (BASE_DIV=4, STEPS=8):
- Reset, play_btn, tempo=0, loop_en=0, manual NONE -> beat_tick every 4 cycles; step_addr 0..7; after 32 cycles done pulse coincides with the 8th tick; state IDLE, note_out NONE next cycle.
- tempo=2 at start, switch to 0 mid-beat -> first beats 12 cycles apart, 4-cycle spacing from the next beat boundary; no short or partial beat.
- PLAY at step 3, beat_cnt 2, play_btn -> note_out NONE next cycle, counters hold for 20 cycles; play_btn -> next tick after 2 more cycles, step 4.
- loop_en=1 -> after step 7 tick, step_addr 0, playing stays 1, no done pulse.
- manual_note=5 held 10 cycles during PLAY -> note_out=5 one cycle after assertion, step/beat_cnt frozen; on release note_out returns to rom_note and counting resumes. In IDLE, manual_note=5 -> note_out=5.
- stop_btn+play_btn same cycle in PLAY -> IDLE, step 0, no done. RESET asserted mid-beat -> all outputs 0/NONE asynchronously.
